// File: rtl/quad_encoder_emu.sv
// quad_encoder_emu
// Multi-axis quadrature / direction-clock encoder emulator. Each axis
// accumulates signed position deltas and drains them as encoder steps at a
// programmable rate. While passthru is high, the external encoder inputs are
// forwarded through one register stage instead.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   delta_valid  per-axis delta offer
//   delta        per-axis signed delta, axis i at [i*DELTA_W +: DELTA_W]
//   delta_ready  per-axis acceptance (headroom left in the accumulator)
//   period       clock cycles between steps (0 and 1 both mean every cycle)
//   mode         0 = quadrature A/B, 1 = direction/clock
//   passthru     1 = forward ext_a/ext_b
//   ext_a/ext_b  external encoder inputs
//   enc_a/enc_b  encoder outputs (registered)
//   busy         accumulator non-zero (registered)
module quad_encoder_emu #(
    parameter int AXES     = 2,
    parameter int DELTA_W  = 8,
    parameter int ACC_W    = 12,
    parameter int PERIOD_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [AXES-1:0]          delta_valid,
    input  logic [AXES*DELTA_W-1:0]  delta,
    output logic [AXES-1:0]          delta_ready,
    input  logic [PERIOD_W-1:0]      period,
    input  logic                     mode,
    input  logic                     passthru,
    input  logic [AXES-1:0]          ext_a,
    input  logic [AXES-1:0]          ext_b,
    output logic [AXES-1:0]          enc_a,
    output logic [AXES-1:0]          enc_b,
    output logic [AXES-1:0]          busy
);

    // Accept window: any in-window acc plus any DELTA_W delta stays representable.
    localparam int ACC_HI_I = (1 << (ACC_W - 1)) - 1 - (1 << (DELTA_W - 1));
    localparam int ACC_LO_I = -(1 << (ACC_W - 1)) + (1 << (DELTA_W - 1));
    localparam logic signed [ACC_W-1:0] ACC_HI   = ACC_W'(ACC_HI_I);
    localparam logic signed [ACC_W-1:0] ACC_LO   = ACC_W'(ACC_LO_I);
    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MONE = {ACC_W{1'b1}};

    // Output encoding: bit 1 = A, bit 0 = B.
    function automatic logic [1:0] encode(input logic m, input logic [1:0] ph, input logic d);
        logic [1:0] ab;
        if (m) begin
            ab = {d, ph[0]};
        end else begin
            ab = {ph[1] ^ ph[0], ph[1]};
        end
        return ab;
    endfunction

    logic signed [ACC_W-1:0] acc_q   [AXES];
    logic signed [ACC_W-1:0] acc_d   [AXES];
    logic [PERIOD_W-1:0]     cnt_q   [AXES];
    logic [PERIOD_W-1:0]     cnt_d   [AXES];
    logic [1:0]              phase_q [AXES];
    logic [1:0]              phase_d [AXES];
    logic [AXES-1:0]         dir_q, dir_d;
    logic [AXES-1:0]         enc_a_q, enc_a_d;
    logic [AXES-1:0]         enc_b_q, enc_b_d;
    logic [AXES-1:0]         busy_q, busy_d;

    logic signed [ACC_W-1:0] dext_s  [AXES];
    logic [AXES-1:0]         ready_s, accept_s, step_s;
    logic [PERIOD_W-1:0]     period_eff_s;
    logic [1:0]              enc_s   [AXES];

    // Effective period: 0 behaves like 1.
    always_comb begin
        if (period == '0) begin
            period_eff_s = PERIOD_W'(1);
        end else begin
            period_eff_s = period;
        end
    end

    // Per-axis next-state: accept, step decision, accumulator, counter, phase, outputs.
    always_comb begin
        ready_s  = '0;
        accept_s = '0;
        step_s   = '0;
        dir_d    = dir_q;
        enc_a_d  = '0;
        enc_b_d  = '0;
        busy_d   = '0;
        for (int i = 0; i < AXES; i++) begin
            dext_s[i]  = {{(ACC_W-DELTA_W){delta[i*DELTA_W + DELTA_W - 1]}},
                          delta[i*DELTA_W +: DELTA_W]};
            ready_s[i] = !passthru && (acc_q[i] >= ACC_LO) && (acc_q[i] <= ACC_HI);
            accept_s[i] = delta_valid[i] && ready_s[i];
            // Compare one bit wider so cnt+1 cannot wrap.
            step_s[i] = !passthru && (acc_q[i] != '0) &&
                        (({1'b0, cnt_q[i]} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, period_eff_s});

            acc_d[i]   = acc_q[i];
            phase_d[i] = phase_q[i];
            cnt_d[i]   = '0;

            if (passthru) begin
                acc_d[i] = '0;
            end else begin
                if (accept_s[i]) begin
                    acc_d[i] = acc_q[i] + dext_s[i];
                end else begin
                    acc_d[i] = acc_q[i];
                end
                // Step direction follows the sign of acc before this edge.
                if (step_s[i]) begin
                    if (acc_q[i][ACC_W-1]) begin
                        acc_d[i]   = acc_d[i] + ACC_ONE;
                        phase_d[i] = phase_q[i] - 2'd1;
                        dir_d[i]   = 1'b1;
                    end else begin
                        acc_d[i]   = acc_d[i] + ACC_MONE;
                        phase_d[i] = phase_q[i] + 2'd1;
                        dir_d[i]   = 1'b0;
                    end
                end else begin
                    phase_d[i] = phase_q[i];
                end
                // Counter runs only while there is something to emit between steps.
                if ((acc_q[i] == '0) || (acc_d[i] == '0) || step_s[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                end
            end

            enc_s[i] = encode(mode, phase_d[i], dir_d[i]);
            if (passthru) begin
                enc_a_d[i] = ext_a[i];
                enc_b_d[i] = ext_b[i];
            end else begin
                enc_a_d[i] = enc_s[i][1];
                enc_b_d[i] = enc_s[i][0];
            end
            busy_d[i] = (acc_d[i] != '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < AXES; i++) begin
                acc_q[i]   <= '0;
                cnt_q[i]   <= '0;
                phase_q[i] <= 2'd0;
            end
            dir_q   <= '0;
            enc_a_q <= '0;
            enc_b_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int i = 0; i < AXES; i++) begin
                acc_q[i]   <= acc_d[i];
                cnt_q[i]   <= cnt_d[i];
                phase_q[i] <= phase_d[i];
            end
            dir_q   <= dir_d;
            enc_a_q <= enc_a_d;
            enc_b_q <= enc_b_d;
            busy_q  <= busy_d;
        end
    end

    assign delta_ready = ready_s;
    assign enc_a       = enc_a_q;
    assign enc_b       = enc_b_q;
    assign busy        = busy_q;

endmodule

// File: doc/quad_encoder_emu.md
QUAD_ENCODER_EMU -- requirements
Module: quad_encoder_emu

Interface
REQ-001 Parameter AXES, default 2: number of independent encoder axes.
REQ-002 Parameter DELTA_W, default 8: width of each signed input delta.
REQ-003 Parameter ACC_W, default 12: width of each signed pending-step accumulator; ACC_W > DELTA_W.
REQ-004 Parameter PERIOD_W, default 16: width of the step-period input.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 delta_valid  in  AXES  per-axis delta offer.
REQ-008 delta  in  AXES*DELTA_W  per-axis signed two's-complement delta; axis i occupies bits [i*DELTA_W +: DELTA_W].
REQ-009 delta_ready  out  AXES  per-axis acceptance; a delta transfers on a cycle where valid and ready are both 1.
REQ-010 period  in  PERIOD_W  clock cycles between emitted steps; values 0 and 1 both mean one step per cycle.
REQ-011 mode  in  1  0 = quadrature A/B output, 1 = direction/clock output.
REQ-012 passthru  in  1  1 = forward external encoder inputs.
REQ-013 ext_a, ext_b  in  AXES each  external encoder inputs used in passthru.
REQ-014 enc_a, enc_b  out  AXES each  encoder outputs.
REQ-015 busy  out  AXES  1 while the axis accumulator is non-zero.

Function
REQ-016 Each axis holds: signed accumulator acc (ACC_W), period counter cnt (PERIOD_W), 2-bit phase, direction bit dir.
REQ-017 delta_ready[i] is 1 iff passthru=0 and -2^(ACC_W-1)+2^(DELTA_W-1) <= acc <= 2^(ACC_W-1)-1-2^(DELTA_W-1); an accepted delta therefore never overflows acc.
REQ-018 Accepted delta is sign-extended to ACC_W and added to acc in the same edge; zero delta is accepted and changes nothing.
REQ-019 While acc=0: cnt holds 0, no steps are emitted.
REQ-020 While acc!=0: cnt increments each cycle; when cnt+1 >= max(period,1), one step is emitted and cnt returns to 0; first step occurs max(period,1) cycles after acc becomes non-zero.
REQ-021 A step with acc>0: phase+1 (mod 4), dir=0, acc-1; with acc<0: phase-1 (mod 4), dir=1, acc+1.
REQ-022 Step and delta accept on the same cycle: acc_next = acc + delta - sign(acc), sign taken from the pre-edge acc.
REQ-023 A delta reversing the sign of acc takes effect on the next step only; no step is emitted when acc_next=0 before the step point.
REQ-024 Quadrature (mode=0): enc_a = phase[1] XOR phase[0], enc_b = phase[1]; sequence for +steps 00,10,11,01 (A,B).
REQ-025 Dir/clock (mode=1): enc_a = dir, enc_b = phase[0] (toggles once per step).
REQ-026 Changing period mid-run applies at the next cnt comparison; cnt already >= new period steps on the next cycle.
REQ-027 Changing mode mid-run changes only output encoding; acc, cnt, phase unaffected.
REQ-028 passthru=1: enc_a/enc_b = ext_a/ext_b registered one cycle; acc and cnt forced to 0 each cycle; phase and dir hold; delta_ready=0; busy=0.
REQ-029 Leaving passthru resumes emulated outputs from held phase on the next cycle.
REQ-030 Axes are fully independent; no shared counters.
REQ-031 All outputs are registered or decoded from registers only; no combinational path from delta/delta_valid to any output except delta_ready via acc.

Reset
REQ-032 reset_n=0 asynchronously clears acc, cnt, phase, dir, and the passthru registers on all axes.
REQ-033 During and after reset: enc_a=0, enc_b=0, busy=0, delta_ready=1 (if passthru=0).
REQ-034 Reset asserted mid-burst discards all pending steps; no further steps after release until a new delta.

Verification
REQ-035 period=4, mode=0, axis0 delta=+3 once -> steps at cycles 4,8,12 after accept; (A,B)=10,11,01; busy falls with last step.
REQ-036 period=2, axis1 delta=-2 -> enc_b toggles twice in mode=1, enc_a=1 throughout stepping; phase ends at 2.
REQ-037 DELTA_W=8, ACC_W=12: feed +127 every cycle -> delta_ready drops when acc > 1919, reasserts after steps drain acc to 1919; acc never exceeds 2047.
REQ-038 acc=+1, period=1, delta=-1 accepted on the step cycle -> acc_next=-1, exactly one + step then one - step.
REQ-039 passthru=1 with ext_a toggling -> enc_a follows one cycle later; delta_ready=0; on release outputs return to held phase.
REQ-040 reset_n pulsed low mid-burst (acc=+50) -> outputs 0 immediately, busy=0, no steps after release.
